// File: rtl/timer_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_sched_pkg : shared types and timer register map for timer_sched_wb8
// Rev 1.0
// ----------------------------------------------------------------------------
package timer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_NOW = 3'd1,
        ST_SCAN   = 3'd2,
        ST_PROG   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_CLR    = 3'd5
    } sched_state_t;

    localparam logic [2:0] ADR_NOW0 = 3'd0;
    localparam logic [2:0] ADR_CMP0 = 3'd4;
    localparam logic [2:0] ADR_CMP3 = 3'd7;

    function automatic int chanw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_sched_wb8_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_sched_wb8_if : 8-bit Wishbone link between scheduler and timer
// Rev 1.0
// ----------------------------------------------------------------------------
interface timer_sched_wb8_if;
    logic [2:0] M_ADR_O;
    logic [7:0] M_DAT_O;
    logic [7:0] M_DAT_I;
    logic       M_WE_O;
    logic       M_STB_O;
    logic       M_ACK_I;

    modport master (
        output M_ADR_O, M_DAT_O, M_WE_O, M_STB_O,
        input  M_DAT_I, M_ACK_I
    );

    modport slave (
        input  M_ADR_O, M_DAT_O, M_WE_O, M_STB_O,
        output M_DAT_I, M_ACK_I
    );
endinterface
`default_nettype wire

// File: rtl/timer_sched_wb8_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb8_master_seq : single registered 8-bit Wishbone access, start/done handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module wb8_master_seq (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       start,
    input  wire logic       we,
    input  wire logic [2:0] adr,
    input  wire logic [7:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [7:0]      rdata,
    timer_sched_wb8_if.master wb
);
    logic       r_stb;
    logic       r_we;
    logic [2:0] r_adr;
    logic [7:0] r_dat;

    // STB falls on the ack edge, so a start in the following cycle still
    // leaves one STB-low cycle between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (!r_stb && start) begin
            r_stb <= 1'b1;
            r_we  <= we;
            r_adr <= adr;
            r_dat <= wdata;
        end else if (r_stb && wb.M_ACK_I) begin
            r_stb <= 1'b0;
        end
    end

    assign busy       = r_stb;
    assign done       = r_stb && wb.M_ACK_I;
    assign rdata      = wb.M_DAT_I;
    assign wb.M_STB_O = r_stb;
    assign wb.M_WE_O  = r_we;
    assign wb.M_ADR_O = r_adr;
    assign wb.M_DAT_O = r_dat;
endmodule
`default_nettype wire

// File: rtl/timer_sched_wb8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_sched_wb8 : multiplexes one ms timer among NCHAN deadline channels
// Rev 1.0
// ----------------------------------------------------------------------------
module timer_sched_wb8
    import timer_sched_pkg::*;
#(
    parameter int NCHAN  = 4,
    parameter int MARGIN = 2
) (
    input  wire logic                     CLK_I,
    input  wire logic                     RST_I,
    input  wire logic                     I_req_valid,
    input  wire logic [chanw(NCHAN)-1:0]  I_req_chan,
    input  wire logic [31:0]              I_req_deadline,
    output logic                          O_req_ready,
    output logic [NCHAN-1:0]              O_expired,
    input  wire logic [NCHAN-1:0]         I_expired_clr,
    input  wire logic                     I_timer_irq,
    timer_sched_wb8_if.master             wb
);
    localparam int CHANW = chanw(NCHAN);

    sched_state_t r_state, w_next;

    logic [31:0]      r_deadline [NCHAN];
    logic [NCHAN-1:0] r_armed, r_expired, w_arm_mask, w_exp_mask;
    logic [31:0]      r_now, r_target, r_best_delta, w_delta;
    logic             r_best_valid, w_due, w_better, w_scan_last;
    logic [1:0]       r_bidx;
    logic [CHANW-1:0] r_sidx;
    logic             w_ready_st, w_accept;

    logic       w_start, w_we, w_busy, w_done;
    logic [2:0] w_adr;
    logic [7:0] w_wdata, w_rdata;

    wb8_master_seq u_seq (
        .clk   (CLK_I),
        .rst   (RST_I),
        .start (w_start),
        .we    (w_we),
        .adr   (w_adr),
        .wdata (w_wdata),
        .busy  (w_busy),
        .done  (w_done),
        .rdata (w_rdata),
        .wb    (wb)
    );

    assign w_ready_st  = (r_state == ST_IDLE) || (r_state == ST_WAIT);
    assign O_req_ready = w_ready_st && !RST_I;
    assign w_accept    = I_req_valid && O_req_ready;
    assign O_expired   = r_expired;

    // Modular delta: bit 31 set means the deadline is already behind now.
    assign w_delta     = r_deadline[r_sidx] - r_now;
    assign w_due       = w_delta[31] || (w_delta <= 32'(MARGIN));
    assign w_better    = r_armed[r_sidx] && !w_due &&
                         (!r_best_valid || (w_delta < r_best_delta));
    assign w_scan_last = (r_sidx == CHANW'(NCHAN - 1));

    always_comb begin
        w_arm_mask = '0;
        w_exp_mask = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_arm_mask[i] = w_accept && (I_req_chan == CHANW'(i));
            w_exp_mask[i] = (r_state == ST_SCAN) && (r_sidx == CHANW'(i)) &&
                            r_armed[i] && w_due;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_we    = 1'b0;
        w_adr   = ADR_NOW0;
        w_wdata = '0;
        case (r_state)
            ST_IDLE, ST_WAIT: begin
                if (w_accept)         w_next = ST_RD_NOW;
                else if (I_timer_irq) w_next = ST_CLR;
            end
            ST_RD_NOW: begin
                w_start = !w_busy;
                w_adr   = ADR_NOW0 + {1'b0, r_bidx};
                if (w_done && (r_bidx == 2'd3)) w_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_scan_last)
                    w_next = (r_best_valid || w_better) ? ST_PROG : ST_IDLE;
            end
            ST_PROG: begin
                w_start = !w_busy;
                w_we    = 1'b1;
                w_adr   = ADR_CMP0 + {1'b0, r_bidx};
                w_wdata = r_target[8*r_bidx +: 8];
                if (w_done && (w_adr == ADR_CMP3)) w_next = ST_WAIT;
            end
            ST_CLR: begin
                w_start = !w_busy;
                w_adr   = ADR_CMP0;
                if (w_done) w_next = ST_RD_NOW;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < NCHAN; i++) r_deadline[i] <= '0;
            r_armed      <= '0;
            r_expired    <= '0;
            r_now        <= '0;
            r_target     <= '0;
            r_best_delta <= '0;
            r_best_valid <= 1'b0;
            r_bidx       <= '0;
            r_sidx       <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++)
                if (w_arm_mask[i]) r_deadline[i] <= I_req_deadline;
            r_armed   <= (r_armed | w_arm_mask) & ~w_exp_mask;
            r_expired <= (r_expired & ~I_expired_clr & ~w_arm_mask) | w_exp_mask;

            if (w_done && (r_state == ST_RD_NOW)) r_now[8*r_bidx +: 8] <= w_rdata;
            if (w_done && ((r_state == ST_RD_NOW) || (r_state == ST_PROG)))
                r_bidx <= r_bidx + 2'd1;

            if (r_state == ST_RD_NOW) begin
                r_best_valid <= 1'b0;
                r_sidx       <= '0;
            end
            if (r_state == ST_SCAN) begin
                r_sidx <= w_scan_last ? '0 : r_sidx + 1'b1;
                if (w_better) begin
                    r_best_valid <= 1'b1;
                    r_best_delta <= w_delta;
                end
                if (w_scan_last)
                    r_target <= r_now + (w_better ? w_delta : r_best_delta);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_timer_sched_wb8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_timer_sched_wb8 : scoreboard bench with a behavioural ms timer model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_timer_sched_wb8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_chan = '0;
    logic [31:0] req_dl = '0;
    logic        ready;
    logic [3:0]  expired;
    logic [3:0]  exp_clr = '0;
    logic        irq = 1'b0;

    always #5 clk = ~clk;

    timer_sched_wb8_if wb ();

    timer_sched_wb8 #(.NCHAN(4), .MARGIN(2)) dut (
        .CLK_I          (clk),
        .RST_I          (rst),
        .I_req_valid    (req_valid),
        .I_req_chan     (req_chan),
        .I_req_deadline (req_dl),
        .O_req_ready    (ready),
        .O_expired      (expired),
        .I_expired_clr  (exp_clr),
        .I_timer_irq    (irq),
        .wb             (wb)
    );

    // Timer model
    logic [31:0] mtime = '0;
    logic [31:0] t_cmp = '0;
    logic [23:0] t_latch = '0;
    logic        t_armed = 1'b0;
    logic        spur = 1'b0;
    logic [7:0]  t_rd;

    always_comb begin
        case (wb.M_ADR_O)
            3'd0:    t_rd = mtime[7:0];
            3'd1:    t_rd = t_latch[7:0];
            3'd2:    t_rd = t_latch[15:8];
            3'd3:    t_rd = t_latch[23:16];
            3'd4:    t_rd = t_cmp[7:0];
            3'd5:    t_rd = t_cmp[15:8];
            3'd6:    t_rd = t_cmp[23:16];
            default: t_rd = t_cmp[31:24];
        endcase
    end
    assign wb.M_DAT_I = t_rd;

    always @(posedge clk) begin
        wb.M_ACK_I <= wb.M_STB_O;
        if (wb.M_STB_O && wb.M_ACK_I) begin
            if (wb.M_WE_O) begin
                case (wb.M_ADR_O)
                    3'd4: begin t_cmp[7:0]   <= wb.M_DAT_O; t_armed <= 1'b0; end
                    3'd5: begin t_cmp[15:8]  <= wb.M_DAT_O; t_armed <= 1'b0; end
                    3'd6: begin t_cmp[23:16] <= wb.M_DAT_O; t_armed <= 1'b0; end
                    3'd7: begin t_cmp[31:24] <= wb.M_DAT_O; t_armed <= 1'b1; end
                    default: ;
                endcase
            end else if (wb.M_ADR_O == 3'd0) begin
                t_latch <= mtime[31:8];
            end else if (wb.M_ADR_O == 3'd4) begin
                irq <= 1'b0;
            end
        end
        if (t_armed && ($signed(mtime - t_cmp) >= 0)) begin
            irq     <= 1'b1;
            t_armed <= 1'b0;
        end
        if (spur) irq <= 1'b1;
    end

    // Scoreboard
    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } bus_t;

    bus_t exp_q[$];
    bus_t mon_e;
    int   nvec = 0;
    int   nfail = 0;

    always @(negedge clk) begin
        if (!rst && wb.M_STB_O && wb.M_ACK_I) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL bus_unexpected got we=%0b adr=%0d dat=%02h expected none",
                         wb.M_WE_O, wb.M_ADR_O, wb.M_DAT_O);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.we !== wb.M_WE_O || mon_e.adr !== wb.M_ADR_O ||
                    (mon_e.we && mon_e.dat !== wb.M_DAT_O)) begin
                    nfail++;
                    $display("FAIL bus got we=%0b adr=%0d dat=%02h expected we=%0b adr=%0d dat=%02h",
                             wb.M_WE_O, wb.M_ADR_O, wb.M_DAT_O, mon_e.we, mon_e.adr, mon_e.dat);
                end
            end
        end
    end

    task automatic push_rd(input logic [2:0] a);
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic push_rdnow();
        for (int i = 0; i < 4; i++) push_rd(3'(i));
    endtask

    task automatic push_prog(input logic [31:0] t);
        for (int i = 0; i < 4; i++) push_wr(3'(4 + i), t[8*i +: 8]);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic arm(input logic [1:0] ch, input logic [31:0] dl);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_chan  = ch;
        req_dl    = dl;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nvec++;
            nfail++;
            $display("FAIL arm_timeout got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic settle(input string name);
        int n = 0;
        repeat (4) @(negedge clk);
        while (!(ready && exp_q.size() == 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (!ready || exp_q.size() != 0) begin
            nfail++;
            $display("FAIL %s got ready=%0b pending=%0d expected ready=1 pending=0",
                     name, ready, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_time(input logic [31:0] t);
        @(negedge clk);
        mtime = t;
    endtask

    task automatic clear_all(input string name);
        @(negedge clk);
        exp_clr = 4'hF;
        @(negedge clk);
        exp_clr = 4'h0;
        chk(name, expired, 4'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stb_cnt;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stb", wb.M_STB_O, 0);
        chk("rst_we", wb.M_WE_O, 0);
        chk("rst_adr", wb.M_ADR_O, 0);
        chk("rst_dat", wb.M_DAT_O, 0);
        chk("rst_ready", ready, 0);
        chk("rst_expired", expired, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", ready, 1);

        // Single channel program and expiry
        mtime = 32'd100;
        push_rdnow(); push_prog(32'd1000); arm(2'd1, 32'd1000); settle("t1_prog");
        chk("t1_pending", expired, 4'b0000);
        push_rd(3'd4); push_rdnow(); set_time(32'd1000); settle("t1_irq");
        chk("t1_expired", expired, 4'b0010);
        clear_all("t1_clr");

        // Earlier deadline reprograms the compare
        push_rdnow(); push_prog(32'd5000); arm(2'd0, 32'd5000); settle("t2_arm0");
        push_rdnow(); push_prog(32'd2000); arm(2'd2, 32'd2000); settle("t2_arm2");
        push_rd(3'd4); push_rdnow(); push_prog(32'd5000); set_time(32'd2000); settle("t2_irq2000");
        chk("t2_exp2", expired, 4'b0100);
        push_rd(3'd4); push_rdnow(); set_time(32'd5000); settle("t2_irq5000");
        chk("t2_exp0", expired, 4'b0101);
        clear_all("t2_clr");

        // Margin boundary and past-due deadlines
        push_rdnow(); arm(2'd3, 32'd5002); settle("t3_margin");
        chk("t3_margin_exp", expired, 4'b1000);
        clear_all("t3_clr_a");
        push_rdnow(); arm(2'd3, 32'd4990); settle("t3_past");
        chk("t3_past_exp", expired, 4'b1000);
        clear_all("t3_clr_b");
        push_rdnow(); push_prog(32'd5003); arm(2'd3, 32'd5003); settle("t3_above");
        chk("t3_above_pending", expired, 4'b0000);
        push_rd(3'd4); push_rdnow(); set_time(32'd5003); settle("t3_irq");
        chk("t3_above_exp", expired, 4'b1000);
        clear_all("t3_clr_c");

        // Wrap-around
        set_time(32'hFFFF_FFF0);
        push_rdnow(); push_prog(32'h0000_0010); arm(2'd0, 32'h0000_0010); settle("t4_arm0");
        push_rdnow(); push_prog(32'hFFFF_FFFF); arm(2'd1, 32'hFFFF_FFFF); settle("t4_arm1");
        push_rd(3'd4); push_rdnow(); push_prog(32'h0000_0010); set_time(32'hFFFF_FFFF);
        settle("t4_irq_a");
        chk("t4_exp1", expired, 4'b0010);
        push_rd(3'd4); push_rdnow(); set_time(32'h0000_0010); settle("t4_irq_b");
        chk("t4_exp0", expired, 4'b0011);
        clear_all("t4_clr");

        // Spurious irq with nothing armed
        push_rd(3'd4); push_rdnow();
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        settle("t5_spur");
        chk("t5_spur_exp", expired, 4'b0000);

        // Set and clear of the same flag in the same cycle
        push_rdnow(); arm(2'd2, 32'h0000_0006);
        n = 0;
        while (!(wb.M_STB_O && wb.M_ACK_I && !wb.M_WE_O && wb.M_ADR_O == 3'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            nvec++;
            nfail++;
            $display("FAIL t5_rd3_timeout got none expected read of adr 3");
        end
        repeat (3) @(negedge clk);
        exp_clr = 4'b0100;
        @(negedge clk);
        exp_clr = 4'b0000;
        settle("t5_setclr");
        chk("t5_set_wins", expired, 4'b0100);

        // Reset in the middle of a compare write
        push_rdnow(); arm(2'd0, 32'h0000_1000);
        n = 0;
        while (!(wb.M_STB_O && wb.M_WE_O && !wb.M_ACK_I) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            nvec++;
            nfail++;
            $display("FAIL t6_prog_timeout got none expected write strobe");
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_stb_drop", wb.M_STB_O, 0);
        chk("t6_expired", expired, 4'b0000);
        chk("t6_ready", ready, 0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", ready, 1);
        stb_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb.M_STB_O) stb_cnt++;
        end
        chk("t6_quiet", stb_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/timer_sched_wb8.md
Name: timer_sched_wb8

Overview:
- Wishbone-B4 8-bit master that multiplexes one hardware millisecond timer (8-byte register map) among NCHAN software deadline channels.
- Keeps a table of armed 32-bit absolute deadlines.
- Reads current time, programs the timer compare register with the earliest pending deadline, and services the timer interrupt.
- Raises a sticky per-channel expiry flag when a deadline is reached.

Parameters:
- NCHAN, 4, number of deadline channels (2..16).
- MARGIN, 2, ms; a deadline within MARGIN of now, or already past, expires immediately without programming the timer.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  synchronous active-high reset
- I_req_valid  in  1  arm or re-arm request
- I_req_chan  in  CHANW  channel index, CHANW = max(1, clog2(NCHAN))
- I_req_deadline  in  32  absolute deadline in ms
- O_req_ready  out  1  request accepted this cycle when valid and ready
- O_expired  out  NCHAN  sticky expiry flags
- I_expired_clr  in  NCHAN  one-cycle clear per flag
- M_ADR_O  out  3  timer register address
- M_DAT_O  out  8  write data
- M_DAT_I  in  8  read data
- M_WE_O  out  1  write enable
- M_STB_O  out  1  strobe
- M_ACK_I  in  1  acknowledge
- I_timer_irq  in  1  timer interrupt, level, cleared by reading address 4

Behaviour:
- Timer register map:
  - 0..3: current ms, LSB first; reading 0 latches bytes 1..3.
  - 4..7: compare value, LSB first; writing 7 arms the timer; reading 4 clears the irq.
  - The timer ACKs one cycle after STB and keeps ACKing while STB stays high.
- Bus access rule:
  - Drive ADR/WE/DAT with STB=1; hold until ACK_I=1.
  - On that cycle capture M_DAT_I for reads, then drive STB=0 for at least one cycle before the next access.
  - Each access takes 3 cycles.
- Reset:
  - STB=0, WE=0, ADR=0, DAT_O=0, O_req_ready=0, O_expired=0.
  - All channels disarmed; state IDLE.
  - Reset mid-access drops STB in the same cycle.
- FSM states:
  - IDLE: ready=1.
    - Request accepted → RD_NOW.
    - Else I_timer_irq → CLR (stale or spurious irq).
  - RD_NOW: 4 reads, address 0,1,2,3; assemble `now`.
  - SCAN: one channel per cycle, NCHAN cycles. For each armed channel compute delta = deadline − now (mod 2^32).
    - If delta[31]=1 or delta ≤ MARGIN: disarm and set O_expired[i].
    - Else track the minimum delta; ties go to the lowest index.
    - End of scan: no candidate → IDLE; else target = now + min delta → PROG.
  - PROG: 4 writes of target, address 4,5,6,7 in that order (address 7 last arms the timer) → WAIT.
  - WAIT: ready=1.
    - Request accepted → RD_NOW (rescan and reprogram).
    - Else I_timer_irq → CLR.
  - CLR: one read of address 4; data discarded → RD_NOW.
- Request handling:
  - Accepted only when ready=1; writes the deadline to the channel and arms it.
  - Re-arming an armed channel overwrites its deadline.
  - Arming also clears O_expired for that channel.
- Requests while not ready: the requester holds valid.
- O_expired set and I_expired_clr for the same bit in the same cycle: set wins.
- Wrap-around: all comparisons use modular deltas. Deadlines up to 2^31−1 ms ahead are valid; anything further is treated as past due.
- Earliest deadline only is programmed. A race where the timer passes the target during PROG is prevented by MARGIN, which must exceed the worst-case RD_NOW+SCAN+PROG duration in ms.
- No combinational path from inputs to M_* outputs; all M_* outputs are registered.

Decomposition:
- Package timer_sched_pkg:
  - FSM state encoding.
  - Timer register address constants: ADR_NOW0=0, ADR_CMP0=4, ADR_CMP3=7.
  - CHANW function.
- One sub-module: wb8_master_seq. It performs a single 8-bit read or write with the STB/ACK/gap rule, using a start/done handshake and returning rdata.
- The FSM and channel table stay in the top level.

Test Plan:
- Reset then arm ch1 deadline=1000 with model time 100 → reads addr 0..3, writes 0xE8,0x03,0x00,0x00 to addr 4..7; model irq at 1000 → read addr 4, O_expired=0010, state IDLE.
- Arm ch0=5000, then ch2=2000 while in WAIT → reprogram compare to 2000. At 2000: O_expired[2]=1, compare reprogrammed to 5000. At 5000: O_expired[0]=1.
- Arm ch3 deadline=now+1 (≤ MARGIN) or now−10 → O_expired[3]=1 after scan, no writes to addr 4..7.
- Wrap: now=0xFFFF_FFF0, ch0 deadline=0x0000_0010 → target 0x0000_0010 programmed, expires after 32 ms; ch1 deadline=0xFFFF_FFFF also armed → ch1 expires first.
- Spurious irq in IDLE with no armed channels → single read of addr 4, back to IDLE, O_expired unchanged; I_expired_clr and a set on the same cycle → bit stays 1.
- RST_I asserted while M_STB_O=1 during PROG → STB=0 next edge, O_expired=0, no further bus activity.
